// File: rtl/mem_access_ctrl.sv
// Load/store controller between a byte-addressed requester and a word-wide memory.
// Sub-word stores use read-modify-write; loads are lane-extracted and sign/zero-extended.
module mem_access_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        we_req,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misalign,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic        r_we;
    logic [1:0]  r_size;
    logic        r_signExt;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic        r_misalign;

    logic        w_accept;
    logic        w_misalignReq;
    logic        w_wordStore;
    logic [31:0] w_loadData;
    logic [31:0] w_merged;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_accept      = (r_state == IDLE) && req;
    assign w_misalignReq = (size == 2'b11)
                         || ((size == 2'b01) && addr[0])
                         || ((size == 2'b00) && (addr[1:0] != 2'b00));
    assign w_wordStore   = we_req && (size == 2'b00);

    assign busy     = (r_state != IDLE);
    assign done     = (r_state == DONE);
    assign misalign = done && r_misalign;
    assign mem_wr   = (r_state == WRITE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (w_misalignReq) begin
                        w_nextState = DONE;
                    end else if (w_wordStore) begin
                        w_nextState = WRITE;
                    end else begin
                        w_nextState = READ;
                    end
                end
            end
            READ:    w_nextState = WAIT;
            WAIT:    w_nextState = r_we ? WRITE : DONE;
            WRITE:   w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Lane selection is little-endian: byte k sits at bits [8k+7:8k].
    always_comb begin
        w_byte     = mem_dout[{r_lane, 3'b000} +: 8];
        w_half     = mem_dout[{r_lane[1], 4'b0000} +: 16];
        w_loadData = 32'h0;
        case (r_size)
            2'b00:   w_loadData = mem_dout;
            2'b01:   w_loadData = {{16{r_signExt & w_half[15]}}, w_half};
            2'b10:   w_loadData = {{24{r_signExt & w_byte[7]}}, w_byte};
            default: w_loadData = 32'h0;
        endcase
    end

    always_comb begin
        w_merged = mem_dout;
        case (r_size)
            2'b01:   w_merged[{r_lane[1], 4'b0000} +: 16] = r_wdata;
            2'b10:   w_merged[{r_lane, 3'b000} +: 8]      = r_wdata[7:0];
            default: w_merged = mem_dout;
        endcase
    end

    // Request attributes are frozen at acceptance so later input changes cannot disturb the access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_signExt  <= 1'b0;
            r_lane     <= 2'b00;
            r_wdata    <= 16'h0;
            r_misalign <= 1'b0;
            rdata      <= 32'h0;
            mem_addr   <= 32'h0;
            mem_din    <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we       <= we_req;
                r_size     <= size;
                r_signExt  <= sign_ext;
                r_lane     <= addr[1:0];
                r_wdata    <= wdata[15:0];
                r_misalign <= w_misalignReq;
                mem_addr   <= {addr[31:2], 2'b00};
                if (!w_misalignReq && w_wordStore) begin
                    mem_din <= wdata;
                end
            end
            if (r_state == WAIT) begin
                if (r_we) begin
                    mem_din <= w_merged;
                end else begin
                    rdata <= w_loadData;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a small behavioural word memory.
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        req;
    logic        we_req;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        misalign;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] mem [0:63];
    logic        preloadEn;
    logic [5:0]  preloadIdx;
    logic [31:0] preloadData;
    int          wrCount;
    logic [31:0] lastWrData;
    logic [31:0] lastWrAddr;

    int checks;
    int errors;
    int cycles;
    int wrBefore;

    mem_access_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .req      (req),
        .we_req   (we_req),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .misalign (misalign),
        .rdata    (rdata),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory returns the word addressed at the previous edge and logs every write strobe.
    always @(posedge clock) begin
        if (preloadEn) begin
            mem[preloadIdx] <= preloadData;
        end else if (mem_wr) begin
            mem[mem_addr[7:2]] <= mem_din;
            wrCount    <= wrCount + 1;
            lastWrData <= mem_din;
            lastWrAddr <= mem_addr;
        end
        mem_dout <= mem[mem_addr[7:2]];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] data);
        @(negedge clock);
        preloadEn   = 1'b1;
        preloadIdx  = idx;
        preloadData = data;
        @(negedge clock);
        preloadEn   = 1'b0;
    endtask

    task automatic applyStimulus(input logic r, input logic we, input logic [1:0] sz,
                                 input logic sx, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clock);
        req      = r;
        we_req   = we;
        size     = sz;
        sign_ext = sx;
        addr     = a;
        wdata    = wd;
    endtask

    // Drops req and scrambles the request inputs right after acceptance, then waits for done.
    task automatic waitDone(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            n++;
            if (i == 0) begin
                req      = 1'b0;
                we_req   = 1'($urandom);
                size     = 2'($urandom);
                sign_ext = 1'($urandom);
                addr     = $urandom;
                wdata    = $urandom;
            end
            if (done) break;
        end
    endtask

    task automatic doAccess(input string tag, input logic we, input logic [1:0] sz, input logic sx,
                            input logic [31:0] a, input logic [31:0] wd, input int expCycles);
        wrBefore = wrCount;
        applyStimulus(1'b1, we, sz, sx, a, wd);
        waitDone(cycles);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(expCycles));
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        wrCount     = 0;
        preloadEn   = 1'b0;
        preloadIdx  = 6'd0;
        preloadData = 32'h0;
        reset       = 1'b0;
        req         = 1'b0;
        we_req      = 1'b0;
        size        = 2'b00;
        sign_ext    = 1'b0;
        addr        = 32'h0;
        wdata       = 32'h0;

        #1;
        checkOutput("rst_busy",     32'(busy),     32'd0);
        checkOutput("rst_done",     32'(done),     32'd0);
        checkOutput("rst_misalign", 32'(misalign), 32'd0);
        checkOutput("rst_mem_wr",   32'(mem_wr),   32'd0);
        checkOutput("rst_rdata",    rdata,         32'h0);
        checkOutput("rst_mem_addr", mem_addr,      32'h0);
        checkOutput("rst_mem_din",  mem_din,       32'h0);

        preload(6'd4, 32'hDEADBEEF);
        preload(6'd8, 32'h11223344);

        $display("[TB] word load, first request at reset release");
        wrBefore = wrCount;
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0);
        reset = 1'b1;
        waitDone(cycles);
        checkOutput("wload_latency",  32'(cycles),   32'd3);
        checkOutput("wload_rdata",    rdata,         32'hDEADBEEF);
        checkOutput("wload_misalign", 32'(misalign), 32'd0);
        checkOutput("wload_mem_addr", mem_addr,      32'h0000_0010);
        checkOutput("wload_nowrite",  32'(wrCount - wrBefore), 32'd0);
        @(negedge clock);
        checkOutput("wload_idle_busy", 32'(busy), 32'd0);
        checkOutput("wload_idle_done", 32'(done), 32'd0);

        preload(6'd4, 32'h80FF7F01);
        doAccess("bload_s3", 1'b0, 2'b10, 1'b1, 32'h0000_0013, 32'h0, 3);
        checkOutput("bload_s3_rdata", rdata, 32'hFFFFFF80);
        doAccess("bload_u3", 1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0, 3);
        checkOutput("bload_u3_rdata", rdata, 32'h00000080);
        doAccess("hload_s2", 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0, 3);
        checkOutput("hload_s2_rdata", rdata, 32'hFFFF80FF);
        doAccess("bload_s0", 1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'h0, 3);
        checkOutput("bload_s0_rdata", rdata, 32'h00000001);

        $display("[TB] halfword read-modify-write store");
        doAccess("hstore", 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000ABCD, 4);
        checkOutput("hstore_wrcount",  32'(wrCount - wrBefore), 32'd1);
        checkOutput("hstore_din",      lastWrData, 32'hABCD3344);
        checkOutput("hstore_addr",     lastWrAddr, 32'h0000_0020);
        checkOutput("hstore_misalign", 32'(misalign), 32'd0);
        doAccess("bload_back", 1'b0, 2'b10, 1'b1, 32'h0000_0023, 32'h0, 3);
        checkOutput("bload_back_rdata", rdata, 32'hFFFFFFAB);

        $display("[TB] misaligned requests");
        doAccess("mis_word", 1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h55555555, 1);
        checkOutput("mis_word_flag",    32'(misalign), 32'd1);
        checkOutput("mis_word_nowrite", 32'(wrCount - wrBefore), 32'd0);
        checkOutput("mis_word_rdata",   rdata, 32'hFFFFFFAB);
        @(negedge clock);
        checkOutput("mis_word_clear", 32'(misalign), 32'd0);
        doAccess("mis_half", 1'b0, 2'b01, 1'b0, 32'h0000_0021, 32'h0, 1);
        checkOutput("mis_half_flag", 32'(misalign), 32'd1);
        doAccess("mis_rsvd", 1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0, 1);
        checkOutput("mis_rsvd_flag",  32'(misalign), 32'd1);
        checkOutput("mis_rsvd_rdata", rdata, 32'hFFFFFFAB);

        doAccess("wstore", 1'b1, 2'b00, 1'b0, 32'h0000_0030, 32'h12345678, 2);
        checkOutput("wstore_wrcount", 32'(wrCount - wrBefore), 32'd1);
        checkOutput("wstore_din",     lastWrData, 32'h12345678);
        checkOutput("wstore_addr",    lastWrAddr, 32'h0000_0030);

        $display("[TB] reset during WAIT of a byte store");
        wrBefore = wrCount;
        applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0041, 32'h0000005A);
        @(negedge clock);
        req = 1'b0;
        @(negedge clock);
        checkOutput("rstmid_busy_before", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rstmid_busy",     32'(busy),   32'd0);
        checkOutput("rstmid_done",     32'(done),   32'd0);
        checkOutput("rstmid_mem_wr",   32'(mem_wr), 32'd0);
        checkOutput("rstmid_rdata",    rdata,       32'h0);
        checkOutput("rstmid_mem_addr", mem_addr,    32'h0);
        checkOutput("rstmid_mem_din",  mem_din,     32'h0);
        repeat (2) @(negedge clock);
        checkOutput("rstmid_nowrite", 32'(wrCount - wrBefore), 32'd0);
        applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0010, 32'h0);
        reset = 1'b1;
        waitDone(cycles);
        checkOutput("rstrel_latency", 32'(cycles), 32'd3);
        checkOutput("rstrel_rdata",   rdata,       32'h80FF7F01);

        $display("[TB] back-to-back word stores with req held");
        begin
            int busyExp [7] = '{1, 1, 0, 1, 1, 0, 0};
            int reqNext [7] = '{1, 1, 1, 0, 1, 0, 0};
            wrBefore = wrCount;
            applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0050, 32'hAAAA0001);
            for (int i = 0; i < 7; i++) begin
                @(negedge clock);
                checkOutput($sformatf("b2b_busy%0d", i), 32'(busy), 32'(busyExp[i]));
                req = 1'(reqNext[i]);
                if (i == 0) wdata = 32'hAAAA0002;
            end
            checkOutput("b2b_wrcount", 32'(wrCount - wrBefore), 32'd2);
            checkOutput("b2b_lastdin", lastWrData, 32'hAAAA0002);
        end

        $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
